// File: rtl/serial_subtractor_param.sv
// Bit-serial LSB-first subtractor: d = a - b - bin over WIDTH bits, one bit per clock.
// Optional signed-overflow output ovf is enabled by defining SERSUB_OVF_EN.
module serial_subtractor_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // One extra counter bit keeps WIDTH itself representable at WIDTH = 2^k.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             br;
    logic             di;
    logic             bnext;
    logic             last_bit;
    logic             accept;
`ifdef SERSUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        di        = a_sr[0] ^ b_sr[0] ^ br;
        bnext     = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        accept    = (state == IDLE) && start;
        last_bit  = (state == SHIFT) && (cnt == LAST);
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    assign busy = (state == SHIFT);

    // NOTE: operand/result shift registers are reset too, so an abandoned operation leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            a_sr <= '0;
            b_sr <= '0;
            r_sr <= '0;
            br   <= 1'b0;
            d    <= '0;
            bout <= 1'b0;
            done <= 1'b0;
`ifdef SERSUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sr <= a;
                b_sr <= b;
                br   <= bin;
                r_sr <= '0;
                cnt  <= '0;
`ifdef SERSUB_OVF_EN
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
`endif
            end else if (state == SHIFT) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                r_sr <= {di, r_sr[WIDTH-1:1]};
                br   <= bnext;
                cnt  <= cnt + CW'(1);
                if (last_bit) begin
                    d    <= {di, r_sr[WIDTH-1:1]};
                    bout <= bnext;
                    done <= 1'b1;
`ifdef SERSUB_OVF_EN
                    // Signed overflow: operand signs differ and the result sign differs from a.
                    ovf <= (a_msb != b_msb) && (di != a_msb);
`endif
                end
            end
        end
    end

endmodule
